cdr_loop_ctrl: RTL and testbench
================================

// Module: cdr_loop_ctrl
// PURPOSE
//  Synthesizable, parametrised digital CDR loop core for the PMA RX path. It replaces the
//  free-running voting clock and first-order filter with a single-clock, second-order loop.
//  Inputs: early/late (Up/Dn) decisions from the bang-bang phase detector.
//  Output: phase-interpolator code, plus a frequency estimate and a lock indication.
//  Sits between the BBPD and the PMIX phase interpolator, on the recovered-clock domain.
// PARAMETERS
//  CODE_W    11  phase-interpolator code width; the code wraps modulo 2**CODE_W
//  CODE_INIT  0  code value after reset
//  VOTE_LEN   3  Up/Dn samples per box-car vote window (>=1)
//  KP         1  proportional step, in code LSBs per vote
//  FREQ_W     8  signed width of the frequency integrator
//  KI_SHIFT   4  integral path: (freq >>> KI_SHIFT) is added to every phase step
//  LOCK_WIN  64  vote windows per lock-evaluation period
//  LOCK_THR   8  max |net vote| over one period that counts as "quiet"
// PORTS
//  clk       in   1       loop clock; all state updates on posedge
//  rst       in   1       synchronous, active-high reset
//  en        in   1       sample enable; 0 freezes the vote window
//  mode      in   1       0 = first-order (proportional only), 1 = second-order
//  up        in   1       BBPD early/late: clock late
//  dn        in   1       BBPD early/late: clock early
//  code      out  CODE_W  phase-interpolator code
//  code_vld  out  1       one-cycle pulse per loop update
//  freq      out  FREQ_W  signed frequency integrator value
//  locked    out  1       high while the lock FSM is in LOCKED
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - code=CODE_INIT, freq=0, code_vld=0, locked=0
//   - window/lock counters and partial sums=0; FSM=ACQ; pending vote dropped
//   - Reset mid-window discards the partial sum.
//  Sample weight per en=1 cycle: up&~dn -> +1; dn&~up -> -1; both or neither -> 0.
//  Vote window:
//   - Counter 0..VOTE_LEN-1 advances only when en=1; en=0 holds counter and sum.
//   - At the cycle where cnt==VOTE_LEN-1 and en=1 (cycle t), the vote is the sign of
//     (sum + current weight): +1, -1, or 0 on a tie. The sum clears for the next window.
//   - Vote registers at t+1, and that pipeline stage is not gated by en.
//  Loop update (edge ending cycle t+1; visible in cycle t+2, code_vld=1 for that cycle):
//   - step = vote*KP + (freq >>> KI_SHIFT), using freq before this update
//   - code <= (code + step) mod 2**CODE_W; wrap both ways (2047+1 -> 0, 0-1 -> 2047)
//   - mode=1: freq <= freq + vote, saturating at +/-(2**(FREQ_W-1)-1); never wraps
//   - mode=0: freq <= 0 on the update; integral term still uses the pre-update freq
//   - code_vld pulses on every vote, including vote 0
//  Lock FSM (evaluated at the end of each LOCK_WIN-vote period; net = signed sum of votes):
//   - ACQ:    |net|<=LOCK_THR -> TRACK, else stay
//   - TRACK:  |net|<=LOCK_THR -> LOCKED, else -> ACQ
//   - LOCKED: |net|>2*LOCK_THR -> ACQ (hysteresis), else stay
//   - net and the period counter clear at each evaluation; locked is registered from state.
//  Latency: 2 cycles from the last sample of a window to code/code_vld update.
// TESTING
//  1 rst=1 for 2 cycles with up=1 -> code=0, freq=0, code_vld=0, locked=0 throughout.
//  2 mode=0, up=1 constant, en=1 -> code +1 every 3 cycles; first code_vld 2 cycles after
//    3rd sample; code 2047 -> 0 wraps.
//  3 Windows {up,dn,none} and {up&dn x3} -> vote 0: code unchanged, code_vld still pulses.
//  4 mode=1, up constant -> freq +1/window; after 16 windows step=2;
//    freq saturates at 127, never 128/-128.
//  5 Alternating up/dn windows for 128 windows -> locked=1 after 2nd period end;
//    then dn constant -> locked=0 at the first period end.
//  6 en=0 for 10 cycles mid-window -> no code_vld, partial sum kept;
//    rst mid-window -> the next window starts from 0.

Source files
------------

// File: rtl/cdr_loop_ctrl.sv
// cdr_loop_ctrl: bang-bang CDR loop core, box-car vote, PI-path filter and lock FSM
module cdr_loop_ctrl #(
  parameter int CODE_W    = 11,
  parameter int CODE_INIT = 0,
  parameter int VOTE_LEN  = 3,
  parameter int KP        = 1,
  parameter int FREQ_W    = 8,
  parameter int KI_SHIFT  = 4,
  parameter int LOCK_WIN  = 64,
  parameter int LOCK_THR  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              up,
  input  logic              dn,
  output logic [CODE_W-1:0] code,
  output logic              code_vld,
  output logic [FREQ_W-1:0] freq,
  output logic              locked
);
  localparam int CW = VOTE_LEN > 1 ? $clog2(VOTE_LEN) : 1;
  localparam int PW = LOCK_WIN > 1 ? $clog2(LOCK_WIN) : 1;
  localparam int SW = $clog2(VOTE_LEN + 1) + 1;
  localparam int NW = $clog2(LOCK_WIN + 1) + 1;
  localparam int FMAX = 2**(FREQ_W-1) - 1;
  localparam logic [1:0] ACQ = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;
  logic [CW-1:0] cnt;
  logic signed [SW-1:0] sum;
  logic signed [1:0] vote;
  logic vote_vld;
  logic [PW-1:0] per;
  logic signed [NW-1:0] net;
  logic [1:0] state, state_nx;
  logic last, per_end;
  int w, tot, step, fnx, ntot, nabs;
  always_comb begin
    w = (up & ~dn) ? 1 : (dn & ~up) ? -1 : 0;
    last = en && cnt == CW'(VOTE_LEN - 1);
    tot = int'(sum) + w;
    step = int'(vote) * KP + (int'($signed(freq)) >>> KI_SHIFT);
    fnx = int'($signed(freq)) + int'(vote);
    fnx = fnx > FMAX ? FMAX : fnx < -FMAX ? -FMAX : fnx;
    ntot = int'(net) + int'(vote);
    nabs = ntot < 0 ? -ntot : ntot;
    per_end = per == PW'(LOCK_WIN - 1);
    state_nx = state == ACQ   ? (nabs <= LOCK_THR ? TRACK : ACQ) :
               state == TRACK ? (nabs <= LOCK_THR ? LOCKED : ACQ) :
                                (nabs > 2*LOCK_THR ? ACQ : LOCKED);
  end
  // vote and loop-update stages run every cycle; only the sampling window honours en
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sum      <= '0;
      vote     <= '0;
      vote_vld <= 1'b0;
      code     <= CODE_W'(CODE_INIT);
      code_vld <= 1'b0;
      freq     <= '0;
      per      <= '0;
      net      <= '0;
      state    <= ACQ;
      locked   <= 1'b0;
    end else begin
      vote_vld <= last;
      code_vld <= vote_vld;
      if (en) begin
        cnt <= last ? '0 : cnt + 1'b1;
        sum <= last ? '0 : SW'(tot);
      end
      if (last) vote <= tot > 0 ? 2'b01 : tot < 0 ? 2'b11 : 2'b00;
      if (vote_vld) begin
        code <= code + CODE_W'(step);
        freq <= mode ? FREQ_W'(fnx) : '0;
        per  <= per_end ? '0 : per + 1'b1;
        net  <= per_end ? '0 : NW'(ntot);
        if (per_end) begin
          state  <= state_nx;
          locked <= state_nx == LOCKED;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// tb_cdr_loop_ctrl: directed checks of vote window, loop update, saturation and lock FSM
module tb_cdr_loop_ctrl;
  logic clk = 0, rst = 1, en = 1, mode = 0, up = 1, dn = 0;
  logic [10:0] code;
  logic code_vld;
  logic [7:0] freq;
  logic locked;
  int errs = 0, chks = 0;
  int n, nv;
  cdr_loop_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .up(up), .dn(dn),
    .code(code), .code_vld(code_vld), .freq(freq), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // one full window of en=1 samples, then one idle cycle: ends in the code_vld cycle
  task automatic win(input logic [2:0] u, input logic [2:0] d);
    en = 1;
    for (int i = 0; i < 3; i++) begin
      up = u[i];
      dn = d[i];
      tick();
    end
    en = 0;
    up = 0;
    dn = 0;
    tick();
  endtask
  task automatic wait_vld(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!code_vld && cyc < 20);
  endtask
  initial begin
    tick();
    check("rst1_code", code, 0);
    check("rst1_freq", freq, 0);
    check("rst1_vld", code_vld, 0);
    check("rst1_lock", locked, 0);
    tick();
    check("rst2_code", code, 0);
    check("rst2_freq", freq, 0);
    check("rst2_vld", code_vld, 0);
    check("rst2_lock", locked, 0);
    rst = 0;
    tick();
    tick();
    tick();
    check("lat_vld_early", code_vld, 0);
    check("lat_code_early", code, 0);
    tick();
    check("lat_vld", code_vld, 1);
    check("lat_code", code, 1);
    wait_vld(n);
    check("period", n, 3);
    check("code2", code, 2);
    for (int k = 3; k <= 2047; k++) wait_vld(n);
    check("code2047", code, 2047);
    wait_vld(n);
    check("wrap_up_vld", code_vld, 1);
    check("wrap_up", code, 0);
    en = 0;
    up = 0;
    rst = 1;
    tick();
    rst = 0;
    win(3'b111, 3'b000);
    check("up_win_vld", code_vld, 1);
    check("up_win_code", code, 1);
    tick();
    check("vld_pulse_end", code_vld, 0);
    win(3'b001, 3'b010);
    check("mix_vld", code_vld, 1);
    check("mix_code", code, 1);
    tick();
    win(3'b111, 3'b111);
    check("both_vld", code_vld, 1);
    check("both_code", code, 1);
    rst = 1;
    tick();
    rst = 0;
    mode = 1;
    for (int k = 1; k <= 16; k++) win(3'b111, 3'b000);
    check("m1_freq16", freq, 16);
    check("m1_code16", code, 16);
    win(3'b111, 3'b000);
    check("m1_step2_code", code, 18);
    check("m1_freq17", freq, 17);
    mode = 0;
    win(3'b111, 3'b000);
    check("m0_code", code, 20);
    check("m0_freq_clr", freq, 0);
    mode = 1;
    for (int k = 0; k < 130; k++) win(3'b111, 3'b000);
    check("sat_pos", freq, 8'h7f);
    for (int k = 0; k < 260; k++) win(3'b000, 3'b111);
    check("sat_neg", freq, 8'h81);
    mode = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int k = 1; k <= 128; k++) begin
      if (k % 2 == 1) win(3'b111, 3'b000);
      else win(3'b000, 3'b111);
      if (k == 64) check("lock_p1", locked, 0);
      if (k == 127) check("lock_pre_p2", locked, 0);
      if (k == 128) check("lock_p2", locked, 1);
    end
    check("alt_code", code, 0);
    for (int k = 1; k <= 64; k++) begin
      win(3'b000, 3'b111);
      if (k == 63) check("lock_hold", locked, 1);
      if (k == 64) check("unlock", locked, 0);
    end
    check("wrap_down", code, 1984);
    rst = 1;
    tick();
    rst = 0;
    en = 1;
    up = 1;
    tick();
    tick();
    en = 0;
    up = 0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (code_vld) nv++;
    end
    check("en0_no_vld", nv, 0);
    en = 1;
    dn = 1;
    tick();
    en = 0;
    dn = 0;
    tick();
    check("en0_vld", code_vld, 1);
    check("en0_sum_kept", code, 1);
    en = 1;
    dn = 1;
    tick();
    tick();
    en = 0;
    dn = 0;
    rst = 1;
    tick();
    rst = 0;
    check("midrst_code", code, 0);
    win(3'b001, 3'b000);
    check("midrst_vld", code_vld, 1);
    check("midrst_code_after", code, 1);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
